// File: rtl/pathfinder_pkg.sv
// Shared pathfinder types. The guarded defines are fallbacks that apply only when constants.v is not compiled first.
`ifndef DEFAULT_MADDR_WIDTH
`define DEFAULT_MADDR_WIDTH 32
`endif
`ifndef DEFAULT_MDATA_WIDTH
`define DEFAULT_MDATA_WIDTH 32
`endif
`ifndef DEFAULT_MAX_NODES
`define DEFAULT_MAX_NODES 16
`endif
`ifndef DEFAULT_INDEX_WIDTH
`define DEFAULT_INDEX_WIDTH 8
`endif
`ifndef NO_PREVIOUS_NODE
`define NO_PREVIOUS_NODE 8'hFF
`endif

package pathfinder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    REQ,
    DONE
  } path_tracer_state_t;

endpackage

// File: rtl/path_tracer_if.sv
// Control, memory-read and path-stream signals of path_tracer.
// The master modport is the tracer side and the slave modport is its environment.
interface path_tracer_if #(
  parameter int MADDR_WIDTH = `DEFAULT_MADDR_WIDTH,
  parameter int MDATA_WIDTH = `DEFAULT_MDATA_WIDTH,
  parameter int INDEX_WIDTH = `DEFAULT_INDEX_WIDTH
);
  logic                   enable;
  logic [INDEX_WIDTH-1:0] source;
  logic [INDEX_WIDTH-1:0] destination;
  logic [INDEX_WIDTH-1:0] number_of_nodes;
  logic [MADDR_WIDTH-1:0] base_address;

  logic                   mem_read_enable;
  logic [MADDR_WIDTH-1:0] mem_addr;
  logic [MDATA_WIDTH-1:0] mem_read_data;
  logic                   mem_read_ready;

  logic [INDEX_WIDTH-1:0] path_node;
  logic                   path_valid;
  logic                   path_ready;
  logic                   path_last;

  logic                   ready;
  logic                   done;
  logic                   error;

  modport master (
    input  enable, source, destination, number_of_nodes, base_address,
    input  mem_read_data, mem_read_ready, path_ready,
    output mem_read_enable, mem_addr, path_node, path_valid, path_last,
    output ready, done, error
  );

  modport slave (
    output enable, source, destination, number_of_nodes, base_address,
    output mem_read_data, mem_read_ready, path_ready,
    input  mem_read_enable, mem_addr, path_node, path_valid, path_last,
    input  ready, done, error
  );
endinterface

// File: rtl/path_addr_gen.sv
// Address of prev[cur]: base + (N*N + cur) * (MADDR_WIDTH/8), modulo 2^MADDR_WIDTH.
// N*N and base are captured on load; the address follows cur combinationally.
module path_addr_gen #(
  parameter int MADDR_WIDTH = `DEFAULT_MADDR_WIDTH,
  parameter int INDEX_WIDTH = `DEFAULT_INDEX_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   load,
  input  logic [INDEX_WIDTH-1:0] number_of_nodes,
  input  logic [MADDR_WIDTH-1:0] base_address,
  input  logic [INDEX_WIDTH-1:0] cur,
  output logic [MADDR_WIDTH-1:0] mem_addr
);
  localparam logic [MADDR_WIDTH-1:0] WORD_BYTES = MADDR_WIDTH'(MADDR_WIDTH / 8);

  logic [MADDR_WIDTH-1:0] nsq;
  logic [MADDR_WIDTH-1:0] base;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      nsq  <= '0;
      base <= '0;
    end else if (load) begin
      nsq  <= MADDR_WIDTH'(number_of_nodes) * MADDR_WIDTH'(number_of_nodes);
      base <= base_address;
    end
  end

  assign mem_addr = base + (nsq + MADDR_WIDTH'(cur)) * WORD_BYTES;
endmodule

// File: rtl/path_tracer.sv
// Walks prev[] from destination back to source and streams the nodes; first beat 1 cycle after enable, memory latency + 1 per hop.
// A beat waits for path_ready with its outputs held. PATH_TRACER_HOP_COUNT_EN adds the hop_count output.
module path_tracer
  import pathfinder_pkg::*;
#(
  parameter int MADDR_WIDTH = `DEFAULT_MADDR_WIDTH,
  parameter int MDATA_WIDTH = `DEFAULT_MDATA_WIDTH,
  parameter int MAX_NODES   = `DEFAULT_MAX_NODES,
  parameter int INDEX_WIDTH = `DEFAULT_INDEX_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  path_tracer_if.master          bus
`ifdef PATH_TRACER_HOP_COUNT_EN
  ,
  output logic [INDEX_WIDTH-1:0] hop_count
`endif
);
  localparam logic [MDATA_WIDTH-1:0] NPN = MDATA_WIDTH'(`NO_PREVIOUS_NODE);

  path_tracer_state_t     state;
  logic [INDEX_WIDTH-1:0] src_q;
  logic [INDEX_WIDTH-1:0] n_q;
  logic [INDEX_WIDTH-1:0] cur;
  logic [INDEX_WIDTH-1:0] hops;
  logic [INDEX_WIDTH-1:0] path_node;
  logic                   path_valid;
  logic                   path_last;
  logic                   mem_read_enable;
  logic                   ready;
  logic                   done;
  logic                   error;

  logic                   start;
  logic                   bad_start;
  logic [MDATA_WIDTH-1:0] rd;
  logic [INDEX_WIDTH-1:0] rd_idx;
  logic                   rd_bad;

  assign start     = (state == IDLE) && bus.enable;
  assign bad_start = (bus.number_of_nodes == '0) || (bus.destination >= bus.number_of_nodes);

  assign rd     = bus.mem_read_data;
  assign rd_idx = rd[INDEX_WIDTH-1:0];
  // The hop guard bounds any cycle in prev[] to N beats.
  assign rd_bad = (rd == NPN) || (rd >= MDATA_WIDTH'(n_q)) || (|(rd >> INDEX_WIDTH))
                || (hops == n_q - INDEX_WIDTH'(1));

  path_addr_gen #(
    .MADDR_WIDTH(MADDR_WIDTH),
    .INDEX_WIDTH(INDEX_WIDTH)
  ) u_addr_gen (
    .clock          (clock),
    .reset          (reset),
    .load           (start),
    .number_of_nodes(bus.number_of_nodes),
    .base_address   (bus.base_address),
    .cur            (cur),
    .mem_addr       (bus.mem_addr)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      src_q           <= '0;
      n_q             <= '0;
      cur             <= '0;
      hops            <= '0;
      path_node       <= '0;
      path_valid      <= 1'b0;
      path_last       <= 1'b0;
      mem_read_enable <= 1'b0;
      ready           <= 1'b1;
      done            <= 1'b0;
      error           <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.enable) begin
            src_q <= bus.source;
            n_q   <= bus.number_of_nodes;
            cur   <= bus.destination;
            hops  <= '0;
            ready <= 1'b0;
            error <= 1'b0;
            if (bad_start) begin
              state <= DONE;
              done  <= 1'b1;
              error <= 1'b1;
            end else begin
              state      <= EMIT;
              path_valid <= 1'b1;
              path_node  <= bus.destination;
              path_last  <= (bus.destination == bus.source);
            end
          end
        end
        EMIT: begin
          if (bus.path_ready) begin
            path_valid <= 1'b0;
            path_last  <= 1'b0;
            if (path_last) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state           <= REQ;
              mem_read_enable <= 1'b1;
            end
          end
        end
        REQ: begin
          if (bus.mem_read_ready) begin
            mem_read_enable <= 1'b0;
            if (rd_bad) begin
              state <= DONE;
              done  <= 1'b1;
              error <= 1'b1;
            end else begin
              cur        <= rd_idx;
              hops       <= hops + INDEX_WIDTH'(1);
              state      <= EMIT;
              path_valid <= 1'b1;
              path_node  <= rd_idx;
              path_last  <= (rd_idx == src_q);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assert property (@(posedge clock) disable iff (!reset)
    start |-> (int'(bus.number_of_nodes) <= MAX_NODES));

  assign bus.path_node       = path_node;
  assign bus.path_valid      = path_valid;
  assign bus.path_last       = path_last;
  assign bus.mem_read_enable = mem_read_enable;
  assign bus.ready           = ready;
  assign bus.done            = done;
  assign bus.error           = error;

`ifdef PATH_TRACER_HOP_COUNT_EN
  assign hop_count = hops;
`endif
endmodule

// File: tb/tb_path_tracer.sv
// Bench for path_tracer: table of prev[] walks over an 8-node graph, a random-latency block RAM,
// a randomly stalling consumer and a beat scoreboard, plus stall and mid-walk reset sequences.
module tb_path_tracer;
  import pathfinder_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 8;
  localparam int MN = 8;
  localparam logic [DW-1:0] NPN32 = DW'(`NO_PREVIOUS_NODE);

  typedef struct {
    logic [7:0][31:0] prev;
    logic [IW-1:0]    src;
    logic [IW-1:0]    dst;
    logic [IW-1:0]    n;
    int               nbeats;
    logic             err;
    int               nreads;
    int               hops;
  } vec_t;

  typedef struct {
    logic [IW-1:0] node;
    logic          last;
  } beat_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  path_tracer_if #(.MADDR_WIDTH(AW), .MDATA_WIDTH(DW), .INDEX_WIDTH(IW)) bus ();
`ifdef PATH_TRACER_HOP_COUNT_EN
  logic [IW-1:0] hop_count;
`endif

  path_tracer #(
    .MADDR_WIDTH(AW),
    .MDATA_WIDTH(DW),
    .MAX_NODES  (MN),
    .INDEX_WIDTH(IW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
`ifdef PATH_TRACER_HOP_COUNT_EN
    ,
    .hop_count(hop_count)
`endif
  );

  logic [DW-1:0] mem [0:79];
  beat_t         sb[$];
  int            checks = 0;
  int            errors = 0;
  int            reads, en_cycles, beats, dones;
  logic          done_err;
  logic [IW-1:0] last_node;
  logic [IW-1:0] cur_n;
  bit            stall_on = 1'b0;
  int            stall_cnt, stall_reads;
  logic [IW-1:0] stall_node;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Block RAM: 0-2 cycles of added latency, one-cycle completion strobe.
  initial begin : responder
    int            lat;
    int            e;
    logic [AW-1:0] a;
    bus.mem_read_ready = 1'b0;
    bus.mem_read_data  = '0;
    forever begin
      @(posedge clock); #1;
      bus.mem_read_ready = 1'b0;
      if (reset && bus.mem_read_enable) begin
        a = bus.mem_addr;
        e = (int'(cur_n) * int'(cur_n) + int'(last_node)) * 4;
        check("mem_addr", a, e);
        lat = $urandom_range(0, 2);
        repeat (lat) begin
          @(posedge clock); #1;
          if (bus.mem_addr !== a) check("mem_addr_stable", bus.mem_addr, a);
        end
        if (reset && bus.mem_read_enable) begin
          bus.mem_read_data  = ((a >> 2) < 80) ? mem[a >> 2] : 32'hDEAD_BEEF;
          bus.mem_read_ready = 1'b1;
          reads++;
        end
      end
    end
  end

  // Consumer: random path_ready, or a 10-cycle hold at the second beat.
  initial begin : consumer
    bus.path_ready = 1'b0;
    forever begin
      @(posedge clock); #1;
      if (stall_on && beats == 1 && bus.path_valid && stall_cnt < 10) begin
        if (stall_cnt == 0) begin
          stall_node  = bus.path_node;
          stall_reads = reads;
        end else begin
          check("stall_node", bus.path_node, stall_node);
          check("stall_valid", bus.path_valid, 1);
        end
        check("stall_no_req", bus.mem_read_enable, 0);
        bus.path_ready = 1'b0;
        stall_cnt++;
        if (stall_cnt == 10) check("stall_reads", reads, stall_reads);
      end else begin
        bus.path_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  always @(negedge clock) begin : monitor
    beat_t e;
    if (reset) begin
      if (bus.mem_read_enable) en_cycles++;
      if (bus.path_valid && bus.path_ready) begin
        beats++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_unexpected actual=%0h required=none", bus.path_node);
        end else begin
          e = sb.pop_front();
          check("beat_node", bus.path_node, e.node);
          check("beat_last", bus.path_last, e.last);
        end
        last_node = bus.path_node;
      end
      if (bus.done) begin
        dones++;
        done_err = bus.error;
      end
    end
  end

  task automatic push_expected(input vec_t v);
    logic [IW-1:0] c;
    logic [DW-1:0] d;
    int            h;
    sb.delete();
    if (v.n == 0 || v.dst >= v.n) return;
    c = v.dst;
    h = 0;
    forever begin
      sb.push_back('{node: c, last: (c == v.src)});
      if (c == v.src) break;
      if (h == int'(v.n) - 1) break;
      d = v.prev[c[2:0]];
      if (d == NPN32 || d >= DW'(v.n)) break;
      c = d[IW-1:0];
      h++;
    end
  endtask

  task automatic start_vec(input vec_t v);
    for (int j = 0; j < 80; j++) mem[j] = 32'hA5A5_0000 | j;
    for (int j = 0; j < 8; j++) mem[64 + j] = v.prev[j];
    cur_n = v.n;
    push_expected(v);
    reads = 0; en_cycles = 0; beats = 0; dones = 0; stall_cnt = 0;
    @(posedge clock); #1;
    check("idle_ready", bus.ready, 1);
    bus.source          = v.src;
    bus.destination     = v.dst;
    bus.number_of_nodes = v.n;
    bus.base_address    = '0;
    bus.enable          = 1'b1;
    @(posedge clock); #1;
    bus.enable = 1'b0;
    check("ready_drop", bus.ready, 0);
    if (v.nbeats > 0) check("first_valid", bus.path_valid, 1);
    else              check("early_done", bus.done, 1);
  endtask

  task automatic run_vec(input vec_t v, input int idx, input bit stall);
    int cyc;
    stall_on = stall;
    start_vec(v);
    cyc = 0;
    while (dones == 0 && cyc < 400) begin
      @(posedge clock); #1;
      cyc++;
    end
    if (dones == 0) begin
      checks++;
      errors++;
      $display("FAIL v%0d_done_timeout actual=%0d required=done", idx, cyc);
    end
    check($sformatf("v%0d_error", idx), done_err, v.err);
    check($sformatf("v%0d_beats", idx), beats, v.nbeats);
    check($sformatf("v%0d_reads", idx), reads, v.nreads);
    check($sformatf("v%0d_sb_left", idx), sb.size(), 0);
    check($sformatf("v%0d_one_done", idx), dones, 1);
    check($sformatf("v%0d_ready_after", idx), bus.ready, 1);
    check($sformatf("v%0d_done_pulse", idx), bus.done, 0);
    if (v.nreads == 0) check($sformatf("v%0d_no_req", idx), en_cycles, 0);
`ifdef PATH_TRACER_HOP_COUNT_EN
    check($sformatf("v%0d_hop_count", idx), hop_count, v.hops);
`endif
    if (stall) check("stall_len", stall_cnt, 10);
    stall_on = 1'b0;
  endtask

  vec_t vt[9];

  initial begin : main
    logic [7:0][31:0] chain;
    logic [7:0][31:0] p;
    int               cyc;

    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : test
    logic [7:0][31:0] chain;
    logic [7:0][31:0] p;
    int               cyc;

    chain[0] = NPN32;
    for (int j = 1; j < 8; j++) chain[j] = 32'(j - 1);
    vt[0] = '{prev: chain, src: 0, dst: 7, n: 8, nbeats: 8, err: 0, nreads: 7, hops: 7};
    vt[1] = '{prev: chain, src: 3, dst: 3, n: 8, nbeats: 1, err: 0, nreads: 0, hops: 0};
    p = chain; p[7] = 4; p[4] = NPN32;
    vt[2] = '{prev: p, src: 0, dst: 7, n: 8, nbeats: 2, err: 1, nreads: 2, hops: 1};
    p = chain; p[7] = 5; p[5] = 7;
    vt[3] = '{prev: p, src: 0, dst: 7, n: 8, nbeats: 8, err: 1, nreads: 8, hops: 7};
    vt[4] = '{prev: chain, src: 0, dst: 0, n: 0, nbeats: 0, err: 1, nreads: 0, hops: 0};
    vt[5] = '{prev: chain, src: 0, dst: 9, n: 8, nbeats: 0, err: 1, nreads: 0, hops: 0};
    p = chain; p[7] = 8;
    vt[6] = '{prev: p, src: 0, dst: 7, n: 8, nbeats: 1, err: 1, nreads: 1, hops: 0};
    vt[7] = '{prev: chain, src: 2, dst: 5, n: 8, nbeats: 4, err: 0, nreads: 3, hops: 3};
    p = chain; p[6] = 32'h0000_0103;
    vt[8] = '{prev: p, src: 0, dst: 6, n: 8, nbeats: 1, err: 1, nreads: 1, hops: 0};

    bus.enable = 1'b0; bus.source = '0; bus.destination = '0;
    bus.number_of_nodes = '0; bus.base_address = '0;
    cur_n = '0; last_node = '0; done_err = 1'b0;

    repeat (2) @(posedge clock);
    #1;
    check("rst_ready", bus.ready, 1);
    check("rst_done", bus.done, 0);
    check("rst_error", bus.error, 0);
    check("rst_valid", bus.path_valid, 0);
    check("rst_last", bus.path_last, 0);
    check("rst_node", bus.path_node, 0);
    check("rst_mem_en", bus.mem_read_enable, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
`ifdef PATH_TRACER_HOP_COUNT_EN
    check("rst_hop_count", hop_count, 0);
`endif
    reset = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(vt[i], i, 1'b0);

    // 10-cycle consumer stall at the second beat
    run_vec(vt[0], 10, 1'b1);

    // reset in the middle of a memory request, then a clean repeat
    start_vec(vt[0]);
    cyc = 0;
    while (!bus.mem_read_enable && cyc < 100) begin
      @(posedge clock); #1;
      cyc++;
    end
    check("req_reached", bus.mem_read_enable, 1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_mem_en", bus.mem_read_enable, 0);
    check("arst_ready", bus.ready, 1);
    check("arst_valid", bus.path_valid, 0);
    sb.delete();
    @(posedge clock); #1;
    reset = 1'b1;
    run_vec(vt[0], 11, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
